// File: rtl/scale_dequant_if.sv
// Handshake and data bundle between the scale FIFO, accumulator stream,
// downstream consumer and the scale_dequant block.
interface scale_dequant_if #(
    parameter int unsigned MAT_SIZE  = 16,
    parameter int unsigned FP_MANT_W = 23,
    parameter int unsigned FP_EXP_W  = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned OUT_W     = 16
) ();
    logic                                  scale_valid_i;
    logic                                  scale_ready_o;
    logic [FP_MANT_W*MAT_SIZE*MAT_SIZE-1:0] scale_mant_i;
    logic [FP_EXP_W*MAT_SIZE*MAT_SIZE-1:0]  scale_exp_i;
    logic                                  acc_valid_i;
    logic                                  acc_ready_o;
    logic [ACC_W*MAT_SIZE-1:0]             acc_row_i;
    logic                                  out_valid_o;
    logic                                  out_ready_i;
    logic [OUT_W*MAT_SIZE-1:0]             out_row_o;
    logic                                  out_last_o;
    logic                                  flush_i;
    logic                                  busy_o;

    // Dequantiser side
    modport slave (
        input  scale_valid_i, scale_mant_i, scale_exp_i,
        input  acc_valid_i, acc_row_i, out_ready_i, flush_i,
        output scale_ready_o, acc_ready_o, out_valid_o, out_row_o, out_last_o, busy_o
    );

    // Environment side (FIFO, accumulator source, sink, controller)
    modport master (
        output scale_valid_i, scale_mant_i, scale_exp_i,
        output acc_valid_i, acc_row_i, out_ready_i, flush_i,
        input  scale_ready_o, acc_ready_o, out_valid_o, out_row_o, out_last_o, busy_o
    );
endinterface

// File: rtl/scale_dequant.sv
// Scales each accumulator row of a tile by per-element FP scales from the
// show-ahead FIFO head; one registered, rounded and saturated row per cycle.
module scale_dequant #(
    parameter int unsigned MAT_SIZE  = 16,
    parameter int unsigned FP_MANT_W = 23,
    parameter int unsigned FP_EXP_W  = 8,
    parameter int unsigned EXP_BIAS  = 127,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned OUT_W     = 16
) (
    input  logic            clk,
    input  logic            rstnn,
    scale_dequant_if.slave  bus
);
    localparam int unsigned RW = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;
    localparam int unsigned PW = ACC_W + FP_MANT_W + 1;
    localparam int unsigned SW = PW + OUT_W;
    localparam logic [RW-1:0]        LAST_ROW = RW'(MAT_SIZE - 1);
    localparam logic signed [SW-1:0] SAT_MAX  = SW'(2**(OUT_W-1) - 1);
    localparam logic signed [SW-1:0] SAT_MIN  = SW'(-(2**(OUT_W-1)));

    logic [RW-1:0]             row_q, row_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic [OUT_W*MAT_SIZE-1:0] out_row_q, out_row_d;
    logic                      busy_q, busy_d;
    logic                      acc_ready_c, accept_c, last_row_c;
    logic [OUT_W*MAT_SIZE-1:0] scaled_row_c;

    // One element: a * 1.m * 2^(e-bias), round half up, saturate
    function automatic logic signed [OUT_W-1:0] dequant(
        input logic signed [ACC_W-1:0] a,
        input logic [FP_MANT_W-1:0]    m,
        input logic [FP_EXP_W-1:0]     e
    );
        logic signed [PW-1:0] p;
        logic signed [SW-1:0] w;
        int s;
        int k;
        p = PW'(a) * $signed({2'b01, m});
        s = int'(EXP_BIAS) + int'(FP_MANT_W) - int'(e);
        k = -s;
        if (e == '0) begin
            w = '0;
        end else if (s > int'(PW)) begin
            w = '0;
        end else if (s > 0) begin
            w = (SW'(p) + (SW'(1) <<< (s - 1))) >>> s;
        end else if (s == 0) begin
            w = SW'(p);
        end else if (k >= int'(OUT_W)) begin
            // any non-zero product shifted this far is out of range
            w = (p == '0) ? '0 : ((p < 0) ? SAT_MIN : SAT_MAX);
        end else begin
            w = SW'(p) <<< k;
        end
        if (w > SAT_MAX)      w = SAT_MAX;
        else if (w < SAT_MIN) w = SAT_MIN;
        return OUT_W'(w);
    endfunction

    assign acc_ready_c = rstnn & bus.scale_valid_i & ~bus.flush_i
                       & (~out_valid_q | bus.out_ready_i);
    assign accept_c    = bus.acc_valid_i & acc_ready_c;
    assign last_row_c  = (row_q == LAST_ROW);

    assign bus.acc_ready_o   = acc_ready_c;
    assign bus.scale_ready_o = accept_c & last_row_c;
    assign bus.out_valid_o   = out_valid_q;
    assign bus.out_last_o    = out_last_q;
    assign bus.out_row_o     = out_row_q;
    assign bus.busy_o        = busy_q;

    // Per-lane datapath, scale row selected by the row counter
    always_comb begin
        scaled_row_c = '0;
        for (int c = 0; c < int'(MAT_SIZE); c++) begin
            scaled_row_c[c*int'(OUT_W) +: OUT_W] = dequant(
                bus.acc_row_i[c*int'(ACC_W) +: ACC_W],
                bus.scale_mant_i[(int'(row_q)*int'(MAT_SIZE) + c)*int'(FP_MANT_W) +: FP_MANT_W],
                bus.scale_exp_i[(int'(row_q)*int'(MAT_SIZE) + c)*int'(FP_EXP_W) +: FP_EXP_W]);
        end
    end

    // Next state: flush beats accept, accept beats drain
    always_comb begin
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_row_d   = out_row_q;
        if (bus.flush_i) begin
            row_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (accept_c) begin
            row_d       = last_row_c ? '0 : row_q + RW'(1);
            out_valid_d = 1'b1;
            out_last_d  = last_row_c;
            out_row_d   = scaled_row_c;
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        busy_d = (row_d != '0);
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_row_q   <= out_row_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_scale_dequant.sv
// Randomised self-checking bench for scale_dequant against an exact
// rational-arithmetic reference of the scaling rule.
module tb_scale_dequant;
    localparam int N  = 16;
    localparam int AW = 32;
    localparam int OW = 16;
    localparam int MW = 23;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic rstnn;
    always #5 clk = ~clk;

    scale_dequant_if bus ();
    scale_dequant dut (.clk(clk), .rstnn(rstnn), .bus(bus.slave));

    int checks = 0;
    int errors = 0;
    int unsigned sc_m [N*N];
    int unsigned sc_e [N*N];
    longint      tile_a [N*N];

    // Exact value a * (2^23+m) * 2^(e-150), rounded half up, saturated
    function automatic logic signed [OW-1:0] ref_y(input longint a, input int unsigned m,
                                                   input int unsigned e);
        logic signed [255:0] n, d, num, den, q;
        int k;
        if (e == 0) return '0;
        n = 256'(a) * 256'(m + 32'd8388608);
        k = int'(e) - 150;
        if (k >= 0) begin
            q = n <<< k;
        end else begin
            d   = 256'(1) <<< (-k);
            num = 2 * n + d;
            den = 2 * d;
            q   = num / den;
            if ((num % den) != 0 && num < 0) q = q - 1;
        end
        if (q > 32767)  return 16'h7fff;
        if (q < -32768) return 16'h8000;
        return 16'(q);
    endfunction

    function automatic logic [N*OW-1:0] exp_row(input int r);
        logic [N*OW-1:0] v;
        for (int c = 0; c < N; c++)
            v[c*OW +: OW] = ref_y(tile_a[r*N+c], sc_m[r*N+c], sc_e[r*N+c]);
        return v;
    endfunction

    task automatic load_scales();
        for (int i = 0; i < N*N; i++) begin
            bus.scale_mant_i[i*MW +: MW] = MW'(sc_m[i]);
            bus.scale_exp_i[i*EW +: EW]  = EW'(sc_e[i]);
        end
    endtask

    task automatic drive_row(input int r);
        for (int c = 0; c < N; c++) bus.acc_row_i[c*AW +: AW] = AW'(tile_a[r*N+c]);
    endtask

    function automatic longint rand_a();
        if ($urandom_range(0, 1) == 0) return longint'(int'($urandom()));
        return longint'($urandom_range(0, 4000)) - 2000;
    endfunction

    task automatic rand_tile();
        for (int i = 0; i < N*N; i++) begin
            tile_a[i] = rand_a();
            sc_m[i]   = $urandom_range(0, 32'h7fffff);
            case ($urandom_range(0, 9))
                0:       sc_e[i] = 0;
                1:       sc_e[i] = 255;
                2:       sc_e[i] = 1;
                default: sc_e[i] = $urandom_range(100, 160);
            endcase
        end
    endtask

    // Streams rows 0..nrows-1 of the current tile and checks every result;
    // optional output stall before stall_row and scale-FIFO gap before row 0
    task automatic stream_tile(input int nrows, input int stall_row, input int stall_len,
                               input int gap_len);
        logic [N*OW-1:0] held, expv;
        load_scales();
        bus.out_ready_i = 1'b1;
        bus.flush_i     = 1'b0;
        if (gap_len > 0) begin
            bus.scale_valid_i = 1'b0;
            bus.acc_valid_i   = 1'b1;
            drive_row(0);
            repeat (gap_len) begin
                @(negedge clk);
                checks++;
                if (bus.acc_ready_o !== 1'b0 || bus.scale_ready_o !== 1'b0)
                    begin errors++; $display("FAIL gap_gating: acc_ready=%b scale_ready=%b expected 0 0", bus.acc_ready_o, bus.scale_ready_o); end
                @(posedge clk); #1;
            end
        end
        bus.scale_valid_i = 1'b1;
        for (int r = 0; r < nrows; r++) begin
            drive_row(r);
            bus.acc_valid_i = 1'b1;
            if (r == stall_row) begin
                held = bus.out_row_o;
                bus.out_ready_i = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    checks++;
                    if (bus.acc_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1 || bus.out_row_o !== held)
                        begin errors++; $display("FAIL stall_hold: acc_ready=%b valid=%b row=%h expected 0 1 %h", bus.acc_ready_o, bus.out_valid_o, bus.out_row_o, held); end
                    @(posedge clk); #1;
                end
                bus.out_ready_i = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (bus.acc_ready_o !== 1'b1)
                begin errors++; $display("FAIL acc_ready row %0d: got %b expected 1", r, bus.acc_ready_o); end
            checks++;
            if (bus.scale_ready_o !== (r == N-1))
                begin errors++; $display("FAIL scale_ready row %0d: got %b expected %b", r, bus.scale_ready_o, (r == N-1)); end
            @(posedge clk); #1;
            expv = exp_row(r);
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.out_last_o !== (r == N-1))
                begin errors++; $display("FAIL valid_last row %0d: got %b%b expected 1%b", r, bus.out_valid_o, bus.out_last_o, (r == N-1)); end
            checks++;
            if (bus.out_row_o !== expv)
                begin errors++; $display("FAIL out_row row %0d: got %h expected %h", r, bus.out_row_o, expv); end
            checks++;
            if (bus.busy_o !== (r != N-1))
                begin errors++; $display("FAIL busy row %0d: got %b expected %b", r, bus.busy_o, (r != N-1)); end
        end
    endtask

    task automatic end_tile();
        bus.acc_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0)
            begin errors++; $display("FAIL drain: valid=%b busy=%b expected 0 0", bus.out_valid_o, bus.busy_o); end
    endtask

    task automatic check_lane(input string name, input int c, input int expv);
        logic signed [OW-1:0] got;
        got = bus.out_row_o[c*OW +: OW];
        checks++;
        if (got !== OW'(expv))
            begin errors++; $display("FAIL %s lane %0d: got %0d expected %0d", name, c, got, expv); end
    endtask

    task automatic test_reset();
        rstnn = 1'b1;
        bus.scale_valid_i = 1'b1; bus.acc_valid_i = 1'b1; bus.out_ready_i = 1'b1;
        bus.flush_i = 1'b0; bus.acc_row_i = '0; bus.scale_mant_i = '0; bus.scale_exp_i = '0;
        #2 rstnn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid_o, bus.out_last_o, bus.busy_o, bus.acc_ready_o, bus.scale_ready_o} !== 5'b0 || bus.out_row_o !== '0)
            begin errors++; $display("FAIL reset: v/l/b/ar/sr=%b%b%b%b%b row=%h expected all 0", bus.out_valid_o, bus.out_last_o, bus.busy_o, bus.acc_ready_o, bus.scale_ready_o, bus.out_row_o); end
        bus.acc_valid_i = 1'b0;
        rstnn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        for (int i = 0; i < N*N; i++) begin
            sc_m[i] = 0; sc_e[i] = 127;
            tile_a[i] = ($urandom_range(0, 1) == 1) ? 100 : -7;
        end
        stream_tile(N, -1, 0, 0);
        for (int c = 0; c < N; c++) check_lane("identity", c, int'(tile_a[(N-1)*N+c]));
        end_tile();
    endtask

    task automatic test_rounding();
        int pat [4];
        pat[0] = 3; pat[1] = -3; pat[2] = 1; pat[3] = -1;
        for (int i = 0; i < N*N; i++) begin
            if (i % N < 8) begin
                sc_e[i] = 126; sc_m[i] = 0; tile_a[i] = pat[i % 4];
            end else begin
                sc_e[i] = 127; sc_m[i] = 32'h400000;
                tile_a[i] = (i % N == 8) ? 3 : longint'($urandom_range(0, 2000)) - 1000;
            end
        end
        stream_tile(N, -1, 0, 0);
        check_lane("round_half", 0, 2);
        check_lane("round_half", 1, -1);
        check_lane("round_half", 2, 1);
        check_lane("round_half", 3, 0);
        check_lane("round_1p5", 8, 5);
        end_tile();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N*N; i++) begin
            sc_m[i] = 0;
            case (i % 5)
                0: begin sc_e[i] = 143; tile_a[i] = 1;  end
                1: begin sc_e[i] = 143; tile_a[i] = -1; end
                2: begin sc_e[i] = 143; tile_a[i] = 0;  end
                3: begin sc_e[i] = 0;   tile_a[i] = rand_a(); end
                default: begin sc_e[i] = 255; sc_m[i] = 32'h7fffff; tile_a[i] = 64'h7fffffff; end
            endcase
        end
        stream_tile(N, -1, 0, 0);
        // row 15 starts at idx 240, 240 % 5 == 0
        check_lane("sat_pos", 0, 32767);
        check_lane("sat_neg", 1, -32768);
        check_lane("sat_zero", 2, 0);
        check_lane("exp_zero", 3, 0);
        check_lane("sat_max", 4, 32767);
        end_tile();
    endtask

    task automatic test_indexing();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                sc_m[r*N+c] = 0; sc_e[r*N+c] = 127 + ((r + c) & 3); tile_a[r*N+c] = 1;
            end
        stream_tile(N, -1, 0, 0);
        for (int c = 0; c < N; c++) check_lane("indexing", c, 1 << ((N - 1 + c) & 3));
        end_tile();
    endtask

    task automatic test_back_to_back();
        rand_tile(); stream_tile(N, -1, 0, 0);
        rand_tile(); stream_tile(N, -1, 0, 0);
        rand_tile(); stream_tile(N, -1, 0, 0);
        end_tile();
    endtask

    task automatic test_backpressure();
        rand_tile(); stream_tile(N, 5, 5, 0);
        rand_tile(); stream_tile(N, -1, 0, 3);
        end_tile();
    endtask

    task automatic test_flush();
        rand_tile();
        stream_tile(7, -1, 0, 0);
        bus.flush_i = 1'b1; bus.acc_valid_i = 1'b1; drive_row(7);
        @(negedge clk);
        checks++;
        if (bus.acc_ready_o !== 1'b0 || bus.scale_ready_o !== 1'b0)
            begin errors++; $display("FAIL flush_gate: acc_ready=%b scale_ready=%b expected 0 0", bus.acc_ready_o, bus.scale_ready_o); end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_last_o !== 1'b0 || bus.busy_o !== 1'b0)
            begin errors++; $display("FAIL flush_state: valid=%b last=%b busy=%b expected 0 0 0", bus.out_valid_o, bus.out_last_o, bus.busy_o); end
        bus.flush_i = 1'b0;
        for (int i = 0; i < N*N; i++) tile_a[i] = rand_a();
        stream_tile(N, -1, 0, 0);
        end_tile();
    endtask

    task automatic test_reset_mid();
        rand_tile();
        stream_tile(5, -1, 0, 0);
        #2 rstnn = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid_o, bus.out_last_o, bus.busy_o, bus.acc_ready_o, bus.scale_ready_o} !== 5'b0 || bus.out_row_o !== '0)
            begin errors++; $display("FAIL reset_mid: v/l/b/ar/sr=%b%b%b%b%b row=%h expected all 0", bus.out_valid_o, bus.out_last_o, bus.busy_o, bus.acc_ready_o, bus.scale_ready_o, bus.out_row_o); end
        @(posedge clk); #1;
        rstnn = 1'b1;
        rand_tile();
        stream_tile(N, -1, 0, 0);
        end_tile();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rounding();
        test_saturation();
        test_indexing();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
